// File: rtl/axi_addr_fifo_if.sv
// One AXI address channel (AR or AW): VALID/READY handshake plus the address-beat payload.
// The master drives valid and the payload; the slave drives ready.
interface axi_addr_fifo_if #(
    parameter int ID_WIDTH   = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 8,
    parameter int SIZE_WIDTH = 3,
    parameter int USER_WIDTH = 1
);
    logic                  valid;
    logic                  ready;
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  len;
    logic [SIZE_WIDTH-1:0] size;
    logic [1:0]            burst;
    logic [USER_WIDTH-1:0] user;

    modport master (
        output valid, id, addr, len, size, burst, user,
        input  ready
    );

    modport slave (
        input  valid, id, addr, len, size, burst, user,
        output ready
    );
endinterface

// File: rtl/axi_addr_fifo.sv
// AXI address-channel buffer: DEPTH entries (any DEPTH >= 2), registered flags and count,
// almost-full threshold and synchronous flush. Head fields come straight from storage.
module axi_addr_fifo #(
    parameter int DEPTH        = 4,
    parameter int ID_WIDTH     = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int LEN_WIDTH    = 8,
    parameter int SIZE_WIDTH   = 3,
    parameter int USER_WIDTH   = 1,
    parameter int AFULL_THRESH = DEPTH - 1,
    localparam int CW          = $clog2(DEPTH + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  flush,
    axi_addr_fifo_if.slave        s,
    axi_addr_fifo_if.master       m,
    output logic [CW-1:0]         count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full
);

    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LEN_WIDTH-1:0]  len;
        logic [SIZE_WIDTH-1:0] size;
        logic [1:0]            burst;
        logic [USER_WIDTH-1:0] user;
    } entry_t;

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push;
    logic            pop;
    entry_t          wr_entry;
    entry_t          head;

    // Explicit wrap so non-power-of-two depths use every slot.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    assign almost_full = (count_q >= CW'(AFULL_THRESH));
    assign count       = count_q;

    assign s.ready = ~full;
    assign m.valid = ~empty;

    assign push = s.valid & ~full;
    assign pop  = m.ready & ~empty;

    assign wr_entry = '{id:    s.id,
                        addr:  s.addr,
                        len:   s.len,
                        size:  s.size,
                        burst: s.burst,
                        user:  s.user};

    assign head    = mem_q[rd_ptr_q];
    assign m.id    = head.id;
    assign m.addr  = head.addr;
    assign m.len   = head.len;
    assign m.size  = head.size;
    assign m.burst = head.burst;
    assign m.user  = head.user;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = next_ptr(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Flush leaves storage untouched; only reset clears it.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !flush) begin
                mem_q[wr_ptr_q] <= wr_entry;
            end
        end
    end

endmodule

// File: doc/axi_addr_fifo.md
# axi_addr_fifo

Parametrised AXI address-channel buffer (AR or AW) sitting between an XBar slave port and the arbiter/decoder stage. It holds up to DEPTH pending address beats with VALID/READY on both sides. Every slot is usable and any DEPTH ≥ 2 is supported, power of two or not. It adds an occupancy count, an almost-full threshold and a synchronous flush. The same module is instantiated for read and write address paths.

## Interface
- DEPTH, 4, number of entries, ≥ 2, any integer
- ID_WIDTH, 4, AxID width
- ADDR_WIDTH, 32, AxADDR width
- LEN_WIDTH, 8, AxLEN width
- SIZE_WIDTH, 3, AxSIZE width
- USER_WIDTH, 1, sideband width (AxUSER/QoS/PROT packing), ≥ 1
- AFULL_THRESH, DEPTH-1, almost_full asserts when count ≥ this value, range 1..DEPTH
- CW (localparam), $clog2(DEPTH+1), count width

Ports:
- ACLK  in  1  clock; all logic on the rising edge
- ARESETn  in  1  reset, synchronous, active-low
- flush  in  1  synchronous clear of queue contents
- s_valid  in  1  upstream entry valid
- s_ready  out  1  FIFO can accept; equals !full
- s_id  in  ID_WIDTH  AxID
- s_addr  in  ADDR_WIDTH  AxADDR
- s_len  in  LEN_WIDTH  AxLEN
- s_size  in  SIZE_WIDTH  AxSIZE
- s_burst  in  2  AxBURST
- s_user  in  USER_WIDTH  sideband
- m_valid  out  1  head entry valid; equals !empty
- m_ready  in  1  downstream takes head
- m_id, m_addr, m_len, m_size, m_burst, m_user  out  matching widths  head-entry fields
- count  out  CW  entries held, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL_THRESH

## Operation
- push = s_valid & s_ready; pop = m_valid & m_ready.
- Storage: DEPTH entries. Each entry holds {id, addr, len, size, burst, user}.
- Pointers: wr_ptr and rd_ptr, each $clog2(DEPTH) bits wide, plus a CW-bit count register.
- Pointer wrap: a pointer advances by 1 and goes from DEPTH-1 back to 0. No reliance on natural binary overflow.
- Push writes the entry at wr_ptr and advances wr_ptr.
- Pop advances rd_ptr.
- Count update: +1 on push only, −1 on pop only, unchanged on push & pop.
- Full: s_ready = 0. Has no combinational dependency on m_ready. A pop while full frees a slot that is visible from the next cycle.
- Empty: m_valid = 0. There is no fall-through path. When empty, push and pop cannot coincide because pop requires m_valid.
- Head outputs: m_* are driven combinationally from the entry at rd_ptr. They must be stable while m_valid = 1 and m_ready = 0.
- flush = 1 sets wr_ptr, rd_ptr and count to 0. It overrides any push or pop in the same cycle; the offered entry is not stored. Storage contents are not cleared.
- Reset (ARESETn = 0 at an edge) sets pointers and count to 0 and clears all storage to 0. Reset overrides flush, push and pop.

## Timing
- Reset values of outputs:
  - s_ready = 1
  - m_valid = 0
  - count = 0
  - full = 0
  - empty = 1
  - almost_full = 0, or 1 only if AFULL_THRESH == 0, which is disallowed
  - all m_* payload fields = 0
- Latency: an entry pushed at edge N is presented with m_valid = 1 after edge N, i.e. one cycle.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Flags and count are registered-state derived: they update only at clock edges, with no combinational path from s_valid or m_ready.
- Reset asserted mid-burst: the queue empties at that edge and no partial state survives. s_ready = 1 in the first cycle after release.

## Test plan
- Reset then idle: hold ARESETn = 0 for 2 cycles, release -> s_ready = 1, m_valid = 0, count = 0, empty = 1, m_addr = 0.
- Fill to full with DEPTH = 5 (non-power-of-two):
  - Stimulus: push addr 0x100, 0x104, ..., 0x110 with m_ready = 0.
  - Required: count = 5, full = 1, s_ready = 0. A 6th s_valid with addr 0x114 is not accepted.
  - Then: drain.
  - Required: exactly 0x100..0x110 appear in order, count goes down to 0.
- Wrap-around with DEPTH = 5:
  - Stimulus: 3 pushes, 3 pops, then 5 pushes, then 5 pops, using ids 0..7.
  - Required: ids pop out in push order across the 4→0 pointer wrap. No entry is lost or duplicated.
- Simultaneous push & pop:
  - At count = 2: count stays 2 and the head advances.
  - At full: the pop is taken and the concurrent s_valid is refused (s_ready = 0). The next cycle s_ready = 1 and count = DEPTH−1.
- Almost-full and backpressure (DEPTH = 4, AFULL_THRESH = 3):
  - almost_full goes to 1 exactly when count becomes 3.
  - With m_ready = 0 held for 10 cycles, m_* holds its value and m_valid stays 1.
- Flush and reset mid-operation:
  - With count = 3, assert flush together with s_valid = 1 and m_ready = 1 -> count = 0, empty = 1, the offered entry is dropped.
  - Refill 2 entries, then assert ARESETn = 0 for one cycle -> count = 0 and m_* = 0.
